// File: rtl/if_pkg.sv
// Shared widths, defaults and helpers for the instruction fetch stage.
package if_pkg;
    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_inst_fifo.sv
// DEPTH-entry queue of {pc4, inst} words with flush and occupancy count.
module if_inst_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = INST_W + ADDR_W,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && (count_q != CW'(DEPTH));
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(do_push);
            rd_ptr_d = rd_ptr_q + AW'(do_pop);
            count_d  = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the head is only meaningful while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, response queue, redirect flush.
// Optional same-cycle response bypass enabled by defining IF_FETCH_BYPASS_EN.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc4_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]        resp_pc_q, resp_pc_d;
    logic [CW-1:0]            outstanding_q, outstanding_d;
    logic [CW-1:0]            discard_q, discard_d;
    logic [CW-1:0]            fifo_count;
    logic [ADDR_W+INST_W-1:0] fifo_head;
    logic [CW:0]              credit_used;
    logic                     issue, resp_keep, fifo_empty, fifo_push, fifo_pop;

    if_inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (redirect_i),
        .push_i      (fifo_push),
        .push_data_i ({resp_pc_q + 32'd4, imem_rdata_i}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    always_comb begin
        fifo_empty  = (fifo_count == '0);
        // Queued entries plus in-flight words (stale ones included) bound the queue.
        credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
        imem_req_o  = !rst_i && !redirect_i && (credit_used < (CW+1)'(DEPTH));
        issue       = imem_req_o && imem_gnt_i;
        resp_keep   = imem_rvalid_i && !redirect_i && (discard_q == '0);

        inst_valid_o = !fifo_empty;
        inst_o       = fifo_empty ? NOP : fifo_head[INST_W-1:0];
        pc4_o        = fifo_empty ? '0 : fifo_head[ADDR_W+INST_W-1:INST_W];
        fifo_push    = resp_keep;
        fifo_pop     = !redirect_i && !stall_i && !fifo_empty;
`ifdef IF_FETCH_BYPASS_EN
        if (resp_keep && fifo_empty) begin
            inst_valid_o = 1'b1;
            inst_o       = imem_rdata_i;
            pc4_o        = resp_pc_q + 32'd4;
            fifo_push    = stall_i;
        end
`endif

        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rvalid_i);
        discard_d     = discard_q;
        if (redirect_i) begin
            fetch_pc_d = word_align(redirect_pc_i);
            resp_pc_d  = word_align(redirect_pc_i);
            discard_d  = outstanding_d;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
            if (resp_keep) resp_pc_d = resp_pc_q + 32'd4;
            if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign imem_addr_o = fetch_pc_q;
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage feeding the IF/ID pipeline register of the 5-stage MIPS core. Owns the PC and issues in-order word requests to an instruction memory port with a grant handshake and variable response latency. Buffers returned instructions in a small queue and presents them with their PC+4. Honours ID-stage stall (hazard unit) and taken-branch redirect, discarding stale in-flight responses.

## Interface
- DEPTH, 4: queue entries and max in-flight requests (power of 2, 2..16)
- RESET_PC, 32'h0000_0000: first fetch address after reset

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- stall_i  in  1  consumer not accepting this cycle (IF_ID_Write low)
- redirect_i  in  1  taken branch/jump from ID; flush and refetch
- redirect_pc_i  in  32  new fetch address; bits [1:0] ignored (forced 0)
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  word-aligned fetch address
- imem_gnt_i  in  1  request accepted this cycle (req && gnt = issued)
- imem_rvalid_i  in  1  response valid, in request order, ≥1 cycle after grant
- imem_rdata_i  in  32  instruction word
- inst_valid_o  out  1  inst_o/pc4_o valid
- inst_o  out  32  instruction to IF/ID
- pc4_o  out  32  address of inst_o plus 4

## Operation
- fetch_pc register; a request is issued when imem_req_o && imem_gnt_i; fetch_pc += 4 on issue, wraps 32'hFFFF_FFFC -> 0.
- imem_req_o = !redirect_i && (occupancy + outstanding < DEPTH); credit rule guarantees queue never overflows.
- outstanding: +1 on issue, -1 on rvalid, both same cycle = unchanged.
- Response accepted into queue as {addr+4, rdata} when discard_cnt == 0; address tracked per in-flight entry (small tag FIFO or pc shadow counter).
- Pop when inst_valid_o && !stall_i.
- Redirect (highest priority, overrides stall): queue emptied; fetch_pc <= {redirect_pc_i[31:2],2'b00}; discard_cnt <= outstanding after this cycle's issue/response accounting; no request issued in redirect cycle; response arriving in redirect cycle dropped.
- While discard_cnt > 0 each rvalid decrements it and is dropped; new-path requests may issue meanwhile (discarded entries still consume credit via outstanding).
- stall_i alone freezes outputs; fetch continues until credits exhausted.

## Timing
- Reset values: imem_req_o 0, imem_addr_o RESET_PC, inst_valid_o 0, inst_o 0, pc4_o 0, queue empty, outstanding 0, discard_cnt 0.
- First cycle after rst_i deasserts: imem_req_o 1, imem_addr_o RESET_PC.
- Grant in cycle N, response in N+L: inst_valid_o in N+L+1 (queued path).
- Redirect in cycle R: inst_valid_o 0 in R+1; first request to target in R+1.
- Back-to-back grants with L=1 and no stall: one instruction per cycle sustained.
- Reset mid-operation: all state cleared immediately; in-flight responses after reset are the memory's responsibility (memory reset on same rst_i).

## Configuration
- IF_FETCH_BYPASS_EN defined: when queue empty, discard_cnt 0, rvalid asserted and not redirect, response drives inst_o/pc4_o combinationally same cycle (latency N+L); if !stall_i it is consumed without a write, else it is written to the queue.
- Undefined: all responses pass through the queue; no combinational rdata->inst_o path.

## Structure
- Package if_pkg: INST_W=32, ADDR_W=32, RESET_PC default, NOP word 32'h0000_0000.
- Sub-module if_inst_fifo: synchronous DEPTH-entry FIFO of {pc4, inst}, with flush, count output, async reset.
- Top holds fetch_pc, outstanding/discard counters, credit logic, bypass mux.

## Test plan
- Reset release, gnt=1, L=1, no stall -> addresses 0,4,8,... issued; inst_o in order, pc4_o 4,8,12 one per cycle from cycle 3.
- stall_i held 10 cycles, gnt=1, L=1 -> exactly DEPTH=4 requests issued then imem_req_o 0; release -> 4 buffered instructions pop in order, no loss.
- L=3, 3 in flight, redirect_i with redirect_pc_i=32'h0000_0103 -> 3 stale responses dropped; next inst_o is word at 0x100 with pc4_o 0x104.
- redirect_i same cycle as rvalid and stall_i=1 -> that response dropped, queue flushed, inst_valid_o 0 next cycle.
- RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; pc4_o FFFF_FFFC, 0000_0000, 0000_0004.
- IF_FETCH_BYPASS_EN, empty queue, L=2 -> inst_valid_o in grant cycle +2; without macro, +3.
